// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: synchronizer, ps2clk glitch filter, 11-bit frame FSM, bit timeout, 1-entry holding register.
// Optional macro PS2_RX_INHIBIT_EN: hold ps2clk low while an unconsumed byte waits between frames.
`timescale 1ns/1ps
module ps2_rx_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overrun,
  output logic [1:0] state_dbg
);

  // Handshake: a byte transfers in every cycle where valid && ready; data is stable while valid is high.

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_FIRE  = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]      FLT_LAST = 4'(FILTER_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_e;

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            fclk_q, fclk_d, strobe_q, strobe_d;
  logic [3:0]      flt_cnt_q, flt_cnt_d;
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d, hold_q, hold_d;
  logic            par_ok_q, par_ok_d, valid_q, valid_d, busy_q, busy_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d, ovr_q, ovr_d;
  logic            oe_q, oe_d, deliver;

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    fclk_d    = fclk_q;
    flt_cnt_d = '0;
    strobe_d  = 1'b0;
    if (clk_s2_q != fclk_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        fclk_d   = clk_s2_q;
        strobe_d = fclk_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    to_cnt_d  = to_cnt_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    terr_d    = 1'b0;
    ovr_d     = 1'b0;
    deliver   = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (!en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end else if (strobe_q) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: if (!dat_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d[bit_cnt_q] = dat_s2_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, dat_s2_q};
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s2_q)     ferr_d  = 1'b1;
          else if (!par_ok_q) perr_d = 1'b1;
          else               deliver = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_FIRE) begin
      // Pulse lands in the cycle the counter would read TIMEOUT_CYCLES-1.
      state_d   = IDLE;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
      terr_d    = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (deliver) begin
      if (!valid_q || ready) begin
        hold_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
`ifdef PS2_RX_INHIBIT_EN
    oe_d = valid_d && !ready && (state_d == IDLE);
`else
    oe_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      fclk_q    <= 1'b1;
      flt_cnt_q <= '0;
      strobe_q  <= 1'b0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b0;
      to_cnt_q  <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      terr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      clk_s1_q  <= ps2clk_in;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2data_in;
      dat_s2_q  <= dat_s1_q;
      fclk_q    <= fclk_d;
      flt_cnt_q <= flt_cnt_d;
      strobe_q  <= strobe_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      to_cnt_q  <= to_cnt_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      terr_q    <= terr_d;
      ovr_q     <= ovr_d;
      oe_q      <= oe_d;
    end
  end

  assign data        = hold_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
  assign overrun     = ovr_q;
  assign ps2clk_oe   = oe_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: directed scenarios plus random frames, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_ps2_rx_ctrl;

  localparam int TO = 300;
  localparam int FL = 4;
  localparam int HP = 20;

  logic       clk = 1'b0, reset_n = 1'b1, en = 1'b1;
  logic       ps2clk_in = 1'b1, ps2data_in = 1'b1, ready = 1'b1;
  logic       ps2clk_oe, valid, busy, parity_err, frame_err, timeout_err, overrun;
  logic [7:0] data;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  ps2_rx_ctrl #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
    .ps2clk_oe(ps2clk_oe), .data(data), .valid(valid), .ready(ready), .busy(busy),
    .parity_err(parity_err), .frame_err(frame_err), .timeout_err(timeout_err),
    .overrun(overrun), .state_dbg(state_dbg)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int n_perr = 0, n_ferr = 0, n_to = 0, n_ovr = 0, n_vhi = 0, n_pop = 0;
  int exp_perr = 0, exp_ferr = 0, exp_to = 0, exp_ovr = 0;
  int last_fall = 0, to_cyc = -1;
  logic mid_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: exp_q doubles as the model of the one-entry holding register.
  always @(negedge clk) begin
    if (reset_n) begin
      if (valid) n_vhi++;
      if (valid && ready) begin
        n_pop++;
        if (exp_q.size() == 0) check("spurious_valid", 1, 0);
        else check("data", data, exp_q.pop_front());
      end
      if (parity_err)  n_perr++;
      if (frame_err)   n_ferr++;
      if (overrun)     n_ovr++;
      if (timeout_err) begin n_to++; to_cyc = cyc; end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_perr"}, n_perr, exp_perr);
    check({tag, "_ferr"}, n_ferr, exp_ferr);
    check({tag, "_tout"}, n_to, exp_to);
    check({tag, "_ovr"}, n_ovr, exp_ovr);
  endtask

  // Drives the first nbits of a frame; the outcome of a complete frame is predicted at the stop-bit fall.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int gl_bit, input int gl_len);
    logic [10:0] f;
    f = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2data_in = f[i];
      repeat (HP) @(negedge clk);
      if (i == 10) begin
        if (!f[10]) exp_ferr++;
        else if ($countones(f[9:1]) % 2 != 1) exp_perr++;
        else if (exp_q.size() != 0 && !ready) exp_ovr++;
        else exp_q.push_back(b);
      end
      ps2clk_in = 1'b0;
      last_fall = cyc;
      repeat (HP) @(negedge clk);
      ps2clk_in = 1'b1;
      if (i == 5) mid_busy = busy;
      if (i == gl_bit) begin
        repeat (4) @(negedge clk);
        ps2clk_in = 1'b0;
        repeat (gl_len) @(negedge clk);
        ps2clk_in = 1'b1;
        repeat (8) @(negedge clk);
        #1 check("glitch_data_state", state_dbg, 1);
      end
    end
    ps2data_in = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  initial begin
    #3 reset_n = 1'b0;
    #1;
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_oe", ps2clk_oe, 0);
    check("rst_errs", {parity_err, frame_err, timeout_err, overrun}, 0);
    check("rst_state", state_dbg, 0);
    settle(3);
    reset_n = 1'b1;
    settle(5);

    // Clean 0x1C frame with ready held high.
    n_vhi = 0;
    send_frame(8'h1C, 0, 0, 11, -1, 0);
    settle(2);
    check("valid_one_cycle", n_vhi, 1);
    check("mid_frame_busy", mid_busy, 1);
    check("busy_after_stop", busy, 0);
    check_counts("good");

    // Bad parity, then bad stop (frame error wins).
    send_frame(8'h1C, 1, 0, 11, -1, 0);
    send_frame(8'h1C, 1, 1, 11, -1, 0);
    settle(2);
    check("err_valid_low", valid, 0);
    check_counts("errs");

    // Timeout after start + 4 data bits, then a 0xF0 frame.
    to_cyc = -1;
    send_frame(8'h00, 0, 0, 5, -1, 0);
    for (int k = 0; k < TO + 100 && to_cyc < 0; k++) @(negedge clk);
    exp_to++;
    check("timeout_latency", to_cyc - last_fall, TO + 2 + FL);
    settle(2);
    check("timeout_busy", busy, 0);
    send_frame(8'hF0, 0, 0, 11, -1, 0);
    settle(2);
    check_counts("tout");

    // Overrun: two frames with ready low.
    set_ready(1'b0);
    send_frame(8'h1C, 0, 0, 11, -1, 0);
    send_frame(8'h32, 0, 0, 11, -1, 0);
    settle(2);
    check("ovr_valid", valid, 1);
    check("ovr_data", data, 8'h1C);
`ifdef PS2_RX_INHIBIT_EN
    check("ovr_oe", ps2clk_oe, 1);
`else
    check("ovr_oe", ps2clk_oe, 0);
`endif
    check_counts("ovr");
    set_ready(1'b1);
    set_ready(1'b0);
    settle(2);
    check("ovr_drained", valid, 0);
    check("ovr_oe_released", ps2clk_oe, 0);
    set_ready(1'b1);

    // Glitches in IDLE and inside the data bits.
    for (int g = 1; g < FL; g += FL - 2) begin
      ps2clk_in = 1'b0;
      repeat (g) @(negedge clk);
      ps2clk_in = 1'b1;
      settle(10);
      check("glitch_idle_state", state_dbg, 0);
      check("glitch_idle_busy", busy, 0);
    end
    send_frame(8'hA5, 0, 0, 11, 3, 1);
    send_frame(8'h3C, 0, 0, 11, 6, FL - 1);
    settle(2);
    check_counts("glitch");

    // en low aborts a frame silently.
    send_frame(8'hAA, 0, 0, 4, -1, 0);
    en = 1'b0;
    settle(3);
    check("en_busy", busy, 0);
    check("en_state", state_dbg, 0);
    settle(TO + 20);
    en = 1'b1;
    send_frame(8'h55, 0, 0, 11, -1, 0);
    settle(2);
    check_counts("en");

    // Asynchronous reset mid-frame with a byte pending.
    set_ready(1'b0);
    send_frame(8'h1C, 0, 0, 11, -1, 0);
    send_frame(8'h5A, 0, 0, 6, -1, 0);
    #3 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", state_dbg, 0);
    settle(2);
    reset_n = 1'b1;
    ready = 1'b1;
    settle(5);
    send_frame(8'h5A, 0, 0, 11, -1, 0);
    settle(2);

    // Random frames, random error injection and consumer stalls.
    for (int r = 0; r < 14; r++) begin
      set_ready(1'($urandom_range(0, 3) != 0));
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0, 11, -1, 0);
    end
    set_ready(1'b1);
    settle(5);
    check_counts("final");
    check("queue_empty", exp_q.size(), 0);
    check("final_valid", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
